bg_mem_arbiter: RTL

- Shares the single-port background tile memory between two requesters: the background pixel fetch path and the CPU memory-mapped port.
- The pixel fetch path has absolute priority during active display. The CPU is serviced in free cycles and during blanking.
- Provides a fixed 1-cycle read latency to the pixel path, a request/ack handshake to the CPU, and a sticky starvation flag for debug.

---
 rtl/bg_mem_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/bg_mem_arbiter.sv
// Background tile memory arbiter. The pixel fetch path has absolute priority during
// active display. The CPU gets free cycles and blanking through a request/ack handshake.
module bg_mem_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 9,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_starved,
  input  logic              starve_clr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic {IDLE, ACK} state_t;

  localparam logic [9:0] H_LIM      = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM      = 10'(V_ACTIVE);
  localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX - 1);

  state_t            state_q, state_d;
  logic              active, pix_gnt, cpu_gnt, cpu_denied;
  logic              ack_rd_q;
  logic [DATA_W-1:0] pix_data_q, rdata_q;
  logic [3:0]        wait_cnt;

  assign active     = (x < H_LIM) && (y < V_LIM);
  assign pix_gnt    = pix_req && active;
  assign cpu_gnt    = cpu_req && !pix_gnt && (state_q == IDLE);
  assign cpu_denied = cpu_req && (state_q == IDLE) && !cpu_gnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_gnt) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data is presented straight from the memory while ack is high, then held.
  always_comb begin
    cpu_ack   = (state_q == ACK);
    cpu_rdata = (cpu_ack && ack_rd_q) ? mem_dout : rdata_q;
    pix_data  = pix_valid ? mem_dout : pix_data_q;
  end

  // The memory port is steered by the grants. A write is blocked while reset is high.
  always_comb begin
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_din  = '0;
    if (pix_gnt) begin
      mem_addr = pix_addr;
    end else if (cpu_gnt) begin
      mem_addr = cpu_addr;
      mem_we   = cpu_we && !rst;
      mem_din  = cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid  <= 1'b0;
      pix_data_q <= '0;
      rdata_q    <= '0;
      ack_rd_q   <= 1'b0;
    end else begin
      pix_valid <= pix_gnt;
      if (pix_valid)            pix_data_q <= mem_dout;
      if (cpu_ack && ack_rd_q)  rdata_q    <= mem_dout;
      if (cpu_gnt)              ack_rd_q   <= !cpu_we;
    end
  end

  // Starvation tracking. When set and clear happen together, set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      cpu_starved <= 1'b0;
    end else begin
      if (cpu_gnt || !cpu_req)                wait_cnt <= '0;
      else if (cpu_denied && wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;

      if (cpu_denied && wait_cnt == STARVE_TOP) cpu_starved <= 1'b1;
      else if (starve_clr)                      cpu_starved <= 1'b0;
    end
  end

endmodule
